// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream (length, bytes, checksum),
// writes it into program memory, optionally reads it back, then launches the computer.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for load_req (or one latched during FIN/ERROR)
//  LEN    | accept length byte (0 means 256)
//  DATA   | accept next program byte
//  WRITE  | drive CS/WE/data_oe for WE_CYCLES clocks
//  CHK    | accept checksum byte and test it
//  VREAD  | read back every byte, READ_LAT clocks each
//  START  | raise turn_ON
//  PULSE  | one-cycle trigger
//  FIN    | done=1, busy=0
//  ERROR  | error code held, busy=0, turn_ON=0
module program_loader #(
   parameter int WE_CYCLES = 2,
   parameter int READ_LAT  = 1,
   parameter bit VERIFY    = 1'b1,
   parameter int TIMEOUT   = 1000
) (
   input  logic       clk,
   input  logic       master_reset_n,
   input  logic       load_req,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] Address,
   output logic [7:0] data_out,
   output logic       data_oe,
   input  logic [7:0] data_in,
   output logic       CS,
   output logic       WE,
   output logic       OE,
   output logic       turn_ON,
   output logic       trigger,
   output logic       busy,
   output logic       done,
   output logic [1:0] error
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_VREAD, S_START, S_PULSE, S_FIN, S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [8:0]    addr_q, addr_d;
   logic [8:0]    n_q, n_d;
   logic [7:0]    wsum_q, wsum_d;
   logic [7:0]    vsum_q, vsum_d;
   logic [2:0]    ph_q, ph_d;
   logic [TW-1:0] to_q, to_d;
   logic [7:0]    aout_q, aout_d;
   logic [7:0]    dout_q, dout_d;
   logic          ton_q, ton_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    err_q, err_d;
   logic          pend_q, pend_d;
   logic          accept, timed_out;

   assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
   assign accept   = in_ready && in_valid;
   assign WE       = (state_q == S_WRITE);
   assign data_oe  = (state_q == S_WRITE);
   assign OE       = (state_q == S_VREAD);
   assign CS       = WE || OE;
   assign trigger  = (state_q == S_PULSE);
   assign Address  = aout_q;
   assign data_out = dout_q;
   assign turn_ON  = ton_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = err_q;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      n_d       = n_q;
      wsum_d    = wsum_q;
      vsum_d    = vsum_q;
      ph_d      = ph_q;
      to_d      = to_q;
      aout_d    = aout_q;
      dout_d    = dout_q;
      ton_d     = ton_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      pend_d    = pend_q;
      timed_out = 1'b0;

      // Idle-wait counter only runs while the loader is asking for a byte.
      if (in_ready) begin
         if (accept) begin
            to_d = '0;
         end else if (TIMEOUT != 0) begin
            if (to_q == TW'(TIMEOUT - 1)) timed_out = 1'b1;
            else                          to_d = to_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (load_req || pend_q) begin
               state_d = S_LEN;
               pend_d  = 1'b0;
               ton_d   = 1'b0;
               done_d  = 1'b0;
               err_d   = 2'b00;
               busy_d  = 1'b1;
               wsum_d  = '0;
               addr_d  = '0;
               to_d    = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               n_d     = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               dout_d  = in_data;
               aout_d  = addr_q[7:0];
               wsum_d  = wsum_q + in_data;
               ph_d    = '0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (ph_q == 3'(WE_CYCLES - 1)) begin
               ph_d    = '0;
               addr_d  = addr_q + 9'd1;
               state_d = (addr_d == n_q) ? S_CHK : S_DATA;
            end else begin
               ph_d = ph_q + 3'd1;
            end
         end
         S_CHK: begin
            if (accept) begin
               if (8'(wsum_q + in_data) != 8'd0) begin
                  state_d = S_ERROR;
                  err_d   = 2'b01;
               end else if (VERIFY) begin
                  state_d = S_VREAD;
                  addr_d  = '0;
                  aout_d  = '0;
                  vsum_d  = '0;
                  ph_d    = '0;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_VREAD: begin
            if (ph_q == 3'(READ_LAT - 1)) begin
               ph_d   = '0;
               vsum_d = vsum_q + data_in;
               addr_d = addr_q + 9'd1;
               aout_d = addr_d[7:0];
               if (addr_d == n_q) begin
                  if (vsum_d != wsum_q) begin
                     state_d = S_ERROR;
                     err_d   = 2'b10;
                  end else begin
                     state_d = S_START;
                  end
               end
            end else begin
               ph_d = ph_q + 3'd1;
            end
         end
         S_START: begin
            ton_d   = 1'b1;
            state_d = S_PULSE;
         end
         S_PULSE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
         end
         S_FIN, S_ERROR: begin
            pend_d  = load_req;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (timed_out && !accept) begin
         state_d = S_ERROR;
         err_d   = 2'b11;
      end
      if (state_d == S_ERROR && state_q != S_ERROR) begin
         busy_d = 1'b0;
         ton_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge master_reset_n) begin
      if (!master_reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         n_q     <= '0;
         wsum_q  <= '0;
         vsum_q  <= '0;
         ph_q    <= '0;
         to_q    <= '0;
         aout_q  <= '0;
         dout_q  <= '0;
         ton_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 2'b00;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         n_q     <= n_d;
         wsum_q  <= wsum_d;
         vsum_q  <= vsum_d;
         ph_q    <= ph_d;
         to_q    <= to_d;
         aout_q  <= aout_d;
         dout_q  <= dout_d;
         ton_q   <= ton_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: memory model on the CS/WE/OE bus, random frames,
// expected results derived from frame contents (checksum and readback sums).
module tb_program_loader;
   localparam int WEC = 2;
   localparam int TO  = 20;

   logic       clk = 1'b0;
   logic       master_reset_n = 1'b0;
   logic       load_req = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] Address, data_out, data_in;
   logic       data_oe, CS, WE, OE, turn_ON, trigger, busy, done;
   logic [1:0] error;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] dat [256];
   logic [7:0] mem [256];
   logic       corrupt_en = 1'b0;
   logic [7:0] corrupt_addr = 8'h00;
   logic [7:0] corrupt_val = 8'h00;

   int we_tot = 0, trig_tot = 0, viol_tot = 0;
   logic [7:0] rd_log [$];
   logic [7:0] wr_log [$];

   always #5 clk = ~clk;

   program_loader #(.WE_CYCLES(WEC), .READ_LAT(1), .VERIFY(1'b1), .TIMEOUT(TO)) dut (
      .clk(clk), .master_reset_n(master_reset_n), .load_req(load_req),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .Address(Address), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
      .CS(CS), .WE(WE), .OE(OE), .turn_ON(turn_ON), .trigger(trigger),
      .busy(busy), .done(done), .error(error)
   );

   always @(posedge clk) if (CS && WE) mem[Address] <= data_out;

   assign data_in = (CS && OE) ?
                    ((corrupt_en && Address == corrupt_addr) ? corrupt_val : mem[Address]) : 8'h00;

   always @(negedge clk) begin
      if (WE) begin we_tot++; wr_log.push_back(Address); end
      if (trigger) trig_tot++;
      if (CS && OE) rd_log.push_back(Address);
      if ((WE && OE) || (data_oe && !WE) || (in_ready && WE) || (CS && !(WE || OE))) viol_tot++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      master_reset_n = 1'b0;
      repeat (2) tick();
      master_reset_n = 1'b1;
      tick();
   endtask

   task automatic drive_byte(input logic [7:0] b, input int max_gap, output bit stuck);
      int guard;
      guard = 0;
      stuck = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 600) begin tick(); guard++; end
      if (!in_ready) stuck = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Runs a whole frame of n bytes from dat[] and checks everything against the model.
   task automatic run_frame(input string name, input int n, input logic [7:0] chk,
                            input int max_gap, input bit spam);
      int we0, tr0, vi0, rd0, wr0, g;
      bit stuck, tmo, tbad, wbad, rbad, mbad;
      logic [7:0] sum, rsum, v;
      logic [1:0] exp_err;
      we0 = we_tot; tr0 = trig_tot; vi0 = viol_tot; rd0 = rd_log.size(); wr0 = wr_log.size();
      stuck = 0; tbad = 0; wbad = 0; rbad = 0; mbad = 0;

      sum = 8'h00; rsum = 8'h00;
      for (int i = 0; i < n; i++) begin
         sum = sum + dat[i];
         v = (corrupt_en && i == int'(corrupt_addr)) ? corrupt_val : dat[i];
         rsum = rsum + v;
      end
      if (8'(sum + chk) != 8'h00) exp_err = 2'b01;
      else if (rsum != sum)      exp_err = 2'b10;
      else                       exp_err = 2'b00;

      load_req = 1'b1; tick(); load_req = 1'b0;
      drive_byte((n == 256) ? 8'h00 : 8'(n), max_gap, tmo); stuck |= tmo;
      for (int i = 0; i < n; i++) begin
         drive_byte(dat[i], max_gap, tmo); stuck |= tmo;
         for (int k = 0; k < WEC; k++) begin
            if (k == 0 && spam) load_req = 1'b1;
            if (!WE || in_ready) tbad = 1;
            tick();
            load_req = 1'b0;
         end
         if (WE || !in_ready) tbad = 1;
      end
      drive_byte(chk, max_gap, tmo); stuck |= tmo;
      g = 0;
      while (busy && g < 600) begin tick(); g++; end

      n_tests++;
      if (stuck || busy) begin
         n_fail++; $display("FAIL %s completion: busy=%0b stuck=%0b, required busy=0", name, busy, stuck);
      end
      n_tests++;
      if (error !== exp_err) begin
         n_fail++; $display("FAIL %s error: got %b, required %b", name, error, exp_err);
      end
      n_tests++;
      if (done !== (exp_err == 2'b00) || turn_ON !== (exp_err == 2'b00)) begin
         n_fail++; $display("FAIL %s done/turn_ON: got %b/%b, required %b", name, done, turn_ON, exp_err == 2'b00);
      end
      n_tests++;
      if ((trig_tot - tr0) != ((exp_err == 2'b00) ? 1 : 0)) begin
         n_fail++; $display("FAIL %s trigger pulses: got %0d, required %0d", name, trig_tot - tr0, (exp_err == 2'b00) ? 1 : 0);
      end
      for (int k = 0; k < wr_log.size() - wr0; k++) if (wr_log[wr0 + k] != 8'(k / WEC)) wbad = 1;
      n_tests++;
      if (wbad || (we_tot - we0) != n * WEC) begin
         n_fail++; $display("FAIL %s write strobes: got %0d WE cycles addr_bad=%0b, required %0d", name, we_tot - we0, wbad, n * WEC);
      end
      for (int i = 0; i < n; i++) if (mem[i] !== dat[i]) mbad = 1;
      n_tests++;
      if (mbad) begin
         n_fail++; $display("FAIL %s memory contents: got mismatching bytes, required dat[0..%0d]", name, n - 1);
      end
      for (int k = 0; k < rd_log.size() - rd0; k++) if (rd_log[rd0 + k] != 8'(k)) rbad = 1;
      n_tests++;
      if (rbad || (rd_log.size() - rd0) != ((exp_err == 2'b01) ? 0 : n)) begin
         n_fail++; $display("FAIL %s readback: got %0d reads addr_bad=%0b, required %0d", name, rd_log.size() - rd0, rbad, (exp_err == 2'b01) ? 0 : n);
      end
      n_tests++;
      if (tbad) begin
         n_fail++; $display("FAIL %s byte timing: got WE/in_ready sequence off, required WE for %0d clocks", name, WEC);
      end
      n_tests++;
      if (viol_tot != vi0) begin
         n_fail++; $display("FAIL %s bus rules: got %0d violations, required 0", name, viol_tot - vi0);
      end
   endtask

   task automatic test_reset();
      master_reset_n = 1'b0;
      #3;
      n_tests++;
      if ({in_ready, Address, data_out, data_oe, CS, WE, OE, turn_ON, trigger, busy, done, error} !== '0) begin
         n_fail++; $display("FAIL reset outputs: got busy=%b done=%b err=%b CS=%b Addr=%h, required all 0", busy, done, error, CS, Address);
      end
      do_reset();
   endtask

   task automatic test_basic();
      dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'h56;
      run_frame("basic", 3, 8'h64, 0, 1'b0);
   endtask

   task automatic test_bad_chk();
      dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'h56;
      run_frame("bad_chk", 3, 8'h65, 1, 1'b0);
   endtask

   task automatic test_verify_err();
      dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'h56;
      corrupt_en = 1'b1; corrupt_addr = 8'h01; corrupt_val = 8'h35;
      run_frame("verify_err", 3, 8'h64, 1, 1'b0);
      corrupt_en = 1'b0;
   endtask

   task automatic test_random();
      int n;
      logic [7:0] s;
      for (int f = 0; f < 8; f++) begin
         n = $urandom_range(24, 1);
         s = 8'h00;
         for (int i = 0; i < n; i++) begin dat[i] = 8'($urandom); s = s + dat[i]; end
         corrupt_en = ($urandom_range(3, 0) == 0);
         corrupt_addr = 8'($urandom_range(n - 1, 0));
         corrupt_val = dat[corrupt_addr] ^ 8'($urandom_range(255, 1));
         s = 8'(-s);
         if ($urandom_range(3, 0) == 0) s = s + 8'($urandom_range(255, 1));
         run_frame("random", n, s, 3, f[0]);
         corrupt_en = 1'b0;
      end
   endtask

   task automatic test_timeout();
      int idle, g;
      bit tmo;
      load_req = 1'b1; tick(); load_req = 1'b0;
      drive_byte(8'h03, 0, tmo);
      drive_byte(8'h12, 0, tmo);
      idle = 0; g = 0;
      while (error != 2'b11 && g < 100) begin
         if (in_ready && !in_valid) idle++;
         tick(); g++;
      end
      n_tests++;
      if (error !== 2'b11 || idle != TO) begin
         n_fail++; $display("FAIL timeout: got error=%b after %0d idle clocks, required 11 after %0d", error, idle, TO);
      end
      n_tests++;
      if (busy !== 1'b0 || turn_ON !== 1'b0) begin
         n_fail++; $display("FAIL timeout state: got busy=%b turn_ON=%b, required 0/0", busy, turn_ON);
      end
      // load_req arrives in the cycle the FSM heads back to IDLE
      dat[0] = 8'hA1; dat[1] = 8'h05;
      run_frame("after_timeout", 2, 8'(-(8'hA1 + 8'h05)), 2, 1'b0);
   endtask

   task automatic test_long();
      for (int i = 0; i < 256; i++) dat[i] = 8'(i);
      run_frame("len256", 256, 8'h80, 0, 1'b0);
   endtask

   task automatic test_reset_mid_write();
      bit tmo;
      load_req = 1'b1; tick(); load_req = 1'b0;
      drive_byte(8'h03, 0, tmo);
      drive_byte(8'h77, 0, tmo);
      load_req = 1'b1; tick(); load_req = 1'b0;
      tick();
      n_tests++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || error !== 2'b00) begin
         n_fail++; $display("FAIL ignored load_req: got busy=%b in_ready=%b error=%b, required 1/1/00", busy, in_ready, error);
      end
      drive_byte(8'h88, 0, tmo);
      n_tests++;
      if (WE !== 1'b1) begin
         n_fail++; $display("FAIL mid-write setup: got WE=%b, required 1", WE);
      end
      master_reset_n = 1'b0;
      #1;
      n_tests++;
      if ({WE, CS, data_oe, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL async reset: got WE/CS/oe/busy=%b, required 0000", {WE, CS, data_oe, busy});
      end
      @(negedge clk);
      master_reset_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      run_frame("after_reset", 4, 8'(-(dat[0] + dat[1] + dat[2] + dat[3])), 1, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500us, required finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_bad_chk();
      test_verify_err();
      test_random();
      test_timeout();
      test_long();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
